arbiter_wrr_lock: RTL
=====================

// Module: arbiter_wrr_lock
// PURPOSE
//  Parametrised successor to the router's top-level arbiter. Weighted round-robin
//  with optional packet lock: a granted requester keeps the grant until its tail
//  flit is accepted, and gets up to WEIGHT consecutive packets before priority rotates.
//  Used for VC and switch allocation, where a packet must not interleave at the output.
// PARAMETERS
//  NUM_REQS  5  number of requesters (>=2)
//  WEIGHT_W  4  width of each per-requester weight field
//  WRR_EN    1  1: weights used; 0: every weight treated as 1 (plain RR)
//  LOCK_EN   1  1: lock until tail; 0: req_tail ignored, every grant single-flit
// PORTS
//  clk        in   1                  clock, rising edge
//  reset      in   1                  asynchronous, active-low (0 = in reset)
//  requests   in   NUM_REQS           request vector
//  req_tail   in   NUM_REQS           current flit of requester i is a tail
//  weights    in   NUM_REQS*WEIGHT_W  packet quota, requester i at [i*WEIGHT_W +: WEIGHT_W]
//  ack        in   1                  downstream accepted the granted flit this cycle
//  lock_clr   in   1                  synchronous lock/quota abort (e.g. VC teardown)
//  grants     out  NUM_REQS           one-hot grant, or all-zero
//  grant_vld  out  1                  |grants
//  grant_id   out  $clog2(NUM_REQS)   index of granted requester (0 when !grant_vld)
//  locked     out  1                  lock state register
// BEHAVIOUR
//  - State: ptr (highest-priority index), lock_q, lock_id, cnt (remaining packet quota).
//  - Reset (reset==0, async): ptr=0, lock_q=0, lock_id=0, cnt=0. grants/grant_vld/grant_id
//    forced 0 while in reset. locked=0.
//  - Grant is combinational from state + requests (0-cycle latency); state updates only on
//    a clk edge where ack && grant_vld. ack without grant_vld: no effect.
//  - UNLOCKED: grant the first requests[i] scanning ptr, ptr+1, ... wrap to 0.
//  - LOCKED: grant lock_id iff requests[lock_id]; else none. No other requester is
//    granted while locked, even if lock_id drops its request.
//  - On accepted flit (ack && grant_vld), requester g:
//    * new owner (g != lock_id or cnt==0): load cnt = eff_w(g) where eff_w = weight,
//      weight 0 -> 1, WRR_EN=0 -> 1. Weight is sampled only at load; later changes
//      take effect on the next load.
//    * non-tail and LOCK_EN: lock_q=1, lock_id=g; cnt unchanged.
//    * tail (or LOCK_EN=0): lock_q=0; cnt = cnt-1 (after load);
//      cnt reaches 0 -> ptr = (g+1) mod NUM_REQS (wrap at NUM_REQS-1 -> 0);
//      cnt >0 -> ptr = g, lock_id = g (g keeps priority for next packet).
//  - Quota hand-off: when unlocked with cnt>0, if requests[ptr]==0 the scan picks the next
//    requester; that grant is a new owner (cnt reloaded) and the old quota is forfeited.
//  - lock_clr: next edge lock_q=0, cnt=0, ptr = (lock_id+1) mod NUM_REQS; priority over
//    a simultaneous ack update; grant in the lock_clr cycle still shown (downstream decides).
//  - Reset mid-packet: lock and quota discarded; arbitration restarts from ptr=0.
//  - cnt width WEIGHT_W; decrement never below 0.
// STRUCTURE
//  - Shared package vr_arb_pkg: ARB_MODE localparams, function onehot_to_idx.
//  - Sub-module arbiter_rr_pick: combinational rotate-priority pick (requests, ptr ->
//    one-hot grant); top keeps the lock/quota registers and selection logic.
// TESTING
//  1 Reset: reset=0 with requests=5'b11111 -> grants=0, locked=0; release -> grants=5'b00001.
//  2 Plain RR (WRR_EN=0 or weights=1), all request, single-flit tails, ack every cycle ->
//    grant_id 0,1,2,3,4,0 (wrap checked).
//  3 Lock: req0 sends 3-flit packet (tail on 3rd), req1 also requesting -> grants=00001
//    for 3 acked cycles, locked=1 after 1st, 0 after 3rd; then 00010.
//  4 Lock hold on bubble: req0 locked drops request 1 cycle -> grants=0 that cycle,
//    req1 not granted; req0 resumes -> granted.
//  5 WRR: weights {1,1,1,1,3}, all request, single-flit -> sequence 0,1,2,3,4,4,4,0;
//    weight 0 on req2 behaves as 1.
//  6 lock_clr mid-packet at req3 with ack same cycle -> next cycle locked=0, ptr=4,
//    grant_id=4; ack with grant_vld=0 changes no state.

Source files
------------

// File: rtl/vr_arb_pkg.sv
// vr_arb_pkg: arbitration mode flags and one-hot to index conversion shared by the arbiters
package vr_arb_pkg;
    localparam int ARB_MODE_WRR = 1;
    localparam int ARB_MODE_LOCK = 2;
    function automatic logic [31:0] onehot_to_idx(input logic [31:0] oh);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) idx = idx | (oh[i] ? 32'(i) : 32'd0);
        return idx;
    endfunction
endpackage

// File: rtl/arbiter_rr_pick.sv
// arbiter_rr_pick: combinational rotate-priority pick of the first request at or after ptr
module arbiter_rr_pick #(
    parameter int NUM_REQS = 5
) (
    input  logic [NUM_REQS-1:0]         requests,
    input  logic [$clog2(NUM_REQS)-1:0] ptr,
    output logic [NUM_REQS-1:0]         grant
);
    logic [NUM_REQS-1:0] hi;
    always_comb begin
        hi = requests & ~((NUM_REQS'(1) << ptr) - NUM_REQS'(1));
        grant = |hi ? (hi & (~hi + NUM_REQS'(1))) : (requests & (~requests + NUM_REQS'(1)));
    end
endmodule

// File: rtl/arbiter_wrr_lock.sv
// arbiter_wrr_lock: weighted round-robin arbiter that holds a grant until the packet tail is accepted
module arbiter_wrr_lock
    import vr_arb_pkg::*;
#(
    parameter int NUM_REQS = 5,
    parameter int WEIGHT_W = 4,
    parameter int WRR_EN   = 1,
    parameter int LOCK_EN  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQS-1:0]           requests,
    input  logic [NUM_REQS-1:0]           req_tail,
    input  logic [NUM_REQS*WEIGHT_W-1:0]  weights,
    input  logic                          ack,
    input  logic                          lock_clr,
    output logic [NUM_REQS-1:0]           grants,
    output logic                          grant_vld,
    output logic [$clog2(NUM_REQS)-1:0]   grant_id,
    output logic                          locked
);
    localparam int ID_W = $clog2(NUM_REQS);
    localparam int MODE = (WRR_EN != 0 ? ARB_MODE_WRR : 0) | (LOCK_EN != 0 ? ARB_MODE_LOCK : 0);
    localparam bit WRR_ON = (MODE & ARB_MODE_WRR) != 0;
    localparam bit LOCK_ON = (MODE & ARB_MODE_LOCK) != 0;
    logic [ID_W-1:0] ptr, lock_id, g;
    logic lock_q, tail, new_owner;
    logic [WEIGHT_W-1:0] cnt, w, cnt_ld, cnt_dec;
    logic [NUM_REQS-1:0] rr_grant;
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] x);
        return (x == ID_W'(NUM_REQS - 1)) ? '0 : x + 1'b1;
    endfunction
    arbiter_rr_pick #(.NUM_REQS(NUM_REQS)) u_pick (
        .requests(requests),
        .ptr     (ptr),
        .grant   (rr_grant)
    );
    always_comb begin
        grants = !reset ? '0 : lock_q ? (requests[lock_id] ? (NUM_REQS'(1) << lock_id) : '0) : rr_grant;
        grant_vld = |grants;
        g = ID_W'(onehot_to_idx(32'(grants)));
        grant_id = g;
        w = WEIGHT_W'(weights >> (g * WEIGHT_W));
        new_owner = (g != lock_id) || (cnt == '0);
        cnt_ld = !new_owner ? cnt : (!WRR_ON || w == '0) ? WEIGHT_W'(1) : w;
        cnt_dec = cnt_ld - 1'b1;
        tail = !LOCK_ON || req_tail[g];
    end
    // lock_clr outranks an accepted flit in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
            lock_q <= 1'b0;
            lock_id <= '0;
            cnt <= '0;
        end else if (lock_clr) begin
            lock_q <= 1'b0;
            cnt <= '0;
            ptr <= wrap_inc(lock_id);
        end else if (ack && grant_vld) begin
            if (!tail) begin
                lock_q <= 1'b1;
                lock_id <= g;
                cnt <= cnt_ld;
            end else begin
                lock_q <= 1'b0;
                cnt <= cnt_dec;
                if (cnt_dec == '0) begin
                    ptr <= wrap_inc(g);
                end else begin
                    ptr <= g;
                    lock_id <= g;
                end
            end
        end
    end
    assign locked = lock_q;
endmodule
